// File: rtl/pingpong_ram.sv
// -----------------------------------------------------------------------------
// pingpong_ram
//
// Double-buffered frame memory. A writer fills one bank while a reader drains
// the other. Each side signals end-of-frame with a one-cycle done pulse. When
// both sides have finished, the banks exchange roles.
//
// Build option:
//   PINGPONG_OUT_REG_EN
//     Undefined (default): read latency is 1 cycle.
//     Defined:             an output register follows the RAM, and read
//                          latency is 2 cycles.
//
// Parameters:
//   WORD_WIDTH  bits per stored word
//   ADDR_WIDTH  per-bank address width (depth per bank = 2**ADDR_WIDTH)
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-high
//   wr_en        write strobe into bank wr_bank
//   wr_address   write word address
//   wr_data      write data
//   wr_done      one-cycle pulse: writer finished its frame
//   rd_en        read strobe from bank ~wr_bank
//   rd_address   read word address
//   rd_done      one-cycle pulse: reader finished its frame
//   rd_data      read data, holds its value while rd_valid is low
//   rd_valid     rd_data carries a requested word this cycle
//   wr_bank      bank currently written; the read bank is ~wr_bank
//   swap         one-cycle pulse when the banks exchange roles
//   frame_ready  the read bank holds at least one completed frame
//
// Frame handshake (registered flags):
//   wr_fin | rd_fin | meaning
//   -------+--------+-------------------------------------------------
//      0   |   0    | both sides still busy on the current frame
//      1   |   0    | writer done, waiting for reader
//      0   |   1    | reader done, waiting for writer (reset state)
//      1   |   1    | swap cycle: toggle bank, clear flags
// -----------------------------------------------------------------------------
module pingpong_ram #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  wr_done,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  input  logic                  rd_done,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  wr_bank,
  output logic                  swap,
  output logic                  frame_ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Both banks live in one array. The bank index is the top address bit, so
  // each bank is one half of the array. Contents are not reset, which keeps
  // the array inferable as block RAM.
  logic [WORD_WIDTH-1:0] mem [0:2*DEPTH-1];

  logic                  wr_fin;
  logic                  rd_fin;
  logic [WORD_WIDTH-1:0] ram_q;
  logic                  ram_valid;

  // ---------------------------------------------------------------------------
  // Frame handshake and bank selection
  // ---------------------------------------------------------------------------
  assign swap = wr_fin & rd_fin;

  // rd_fin resets to 1, so the writer's first frame swaps without a reader.
  // A done pulse that arrives in the swap cycle is loaded into the cleared
  // flag. That way it counts toward the next frame instead of being lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank     <= 1'b0;
      wr_fin      <= 1'b0;
      rd_fin      <= 1'b1;
      frame_ready <= 1'b0;
    end else if (swap) begin
      wr_bank     <= ~wr_bank;
      wr_fin      <= wr_done;
      rd_fin      <= rd_done;
      frame_ready <= 1'b1;
    end else begin
      wr_fin      <= wr_fin | wr_done;
      rd_fin      <= rd_fin | rd_done;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory. Writes and reads target opposite banks, so they never collide.
  // In the swap cycle, both sides still use the old wr_bank.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_address}] <= wr_data;
    end
  end

  // The bank is captured together with the address in the rd_en cycle. A
  // swap on the same edge therefore cannot redirect the read.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      ram_q <= mem[{~wr_bank, rd_address}];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_valid <= 1'b0;
    end else begin
      ram_valid <= rd_en;
    end
  end

`ifdef PINGPONG_OUT_REG_EN
  // ---------------------------------------------------------------------------
  // Registered output, 2-cycle latency.
  // ---------------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] out_q;
  logic                  out_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= ram_valid;
      if (ram_valid) begin
        out_q <= ram_q;
      end
    end
  end

  assign rd_data  = out_q;
  assign rd_valid = out_valid;
`else
  // ---------------------------------------------------------------------------
  // Direct RAM output, 1-cycle latency.
  // ram_q has no reset, so it stays a plain RAM output latch. have_data
  // forces rd_data to zero from reset until the first read lands. After
  // that, ram_q only changes on rd_en, so rd_data holds between reads.
  // ---------------------------------------------------------------------------
  logic have_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_data <= 1'b0;
    end else if (rd_en) begin
      have_data <= 1'b1;
    end
  end

  assign rd_data  = have_data ? ram_q : '0;
  assign rd_valid = ram_valid;
`endif

endmodule

// File: tb/tb_pingpong_ram.sv
module tb_pingpong_ram;

  localparam int W = 16;
  localparam int A = 10;
`ifdef PINGPONG_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         wr_en, wr_done, rd_en, rd_done;
  logic [A-1:0] wr_address, rd_address;
  logic [W-1:0] wr_data, rd_data;
  logic         rd_valid, wr_bank, swap, frame_ready;

  pingpong_ram #(.WORD_WIDTH(W), .ADDR_WIDTH(A)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data), .wr_done(wr_done),
    .rd_en(rd_en), .rd_address(rd_address), .rd_done(rd_done),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_bank(wr_bank), .swap(swap), .frame_ready(frame_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
  endtask

  task automatic read(input logic [A-1:0] addr, input logic [W-1:0] exp);
    rd_en = 1;
    rd_address = addr;
    sb.push_back('{exp, cyc + LAT});
  endtask

  // Monitor: pops the scoreboard whenever rd_valid is seen. It also checks
  // that rd_data holds the last expected word while rd_valid is low.
  always @(negedge clk) begin
    if (reset) begin
      chk("rd_valid_in_reset", {31'b0, rd_valid}, 32'd0);
      last_exp = '0;
    end else if (rd_valid) begin
      if (sb.size() == 0) begin
        chk("rd_valid_unexpected", {31'b0, rd_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_data", {16'b0, rd_data}, {16'b0, e.data});
        chk("rd_latency", cyc, e.due);
        last_exp = e.data;
      end
    end else begin
      chk("rd_data_hold", {16'b0, rd_data}, {16'b0, last_exp});
    end
  end

  initial begin
    int t;
    idle();
    wr_address = '0; wr_data = '0; rd_address = '0;
    #2 reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_bank", {31'b0, wr_bank}, 0);
    chk("rst_swap", {31'b0, swap}, 0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 0);
    chk("rst_rd_data", {16'b0, rd_data}, 0);
    chk("rst_frame_ready", {31'b0, frame_ready}, 0);
    next();
    reset = 0;
    next();

    // Fill bank 0 with words 0x00AA..0x00AD at addresses 0..3.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_address = A'(i); wr_data = W'(16'h00AA + i);
      @(negedge clk);
      chk("swap_during_fill", {31'b0, swap}, 0);
      next();
    end
    wr_en = 0;
    wr_done = 1;
    @(negedge clk);
    chk("swap_in_wr_done_cycle", {31'b0, swap}, 0);
    next();
    wr_done = 0;
    @(negedge clk);
    chk("first_swap", {31'b0, swap}, 1);
    chk("wr_bank_in_swap", {31'b0, wr_bank}, 0);
    next();
    @(negedge clk);
    chk("swap_one_cycle", {31'b0, swap}, 0);
    chk("wr_bank_after_swap", {31'b0, wr_bank}, 1);
    chk("frame_ready_after_swap", {31'b0, frame_ready}, 1);

    // Read bank 0 while bank 1 is written at the same addresses.
    read(2, 16'h00AC); wr_en = 1; wr_address = 2; wr_data = 16'h1234;
    next();
    read(0, 16'h00AA); wr_address = 0; wr_data = 16'h5555;
    next();
    read(3, 16'h00AD); wr_en = 0;
    next();
    idle();
    repeat (4) next();

    // Flag timing, with a done pulse in the swap cycle and a write in the
    // swap cycle. Expected swaps at i=6 and i=10.
    for (int i = 0; i < 12; i++) begin
      idle();
      wr_done = (i == 0 || i == 2 || i == 9);
      rd_done = (i == 5 || i == 6);
      if (i == 7)  read(2, 16'h1234);
      if (i == 8)  read(0, 16'h5555);
      if (i == 10) read(2, 16'h1234);
      if (i == 8)  begin wr_en = 1; wr_address = 1; wr_data = 16'hBEEF; end
      if (i == 10) begin wr_en = 1; wr_address = 3; wr_data = 16'h7777; end
      @(negedge clk);
      chk($sformatf("swap_seq_%0d", i), {31'b0, swap}, {31'b0, (i == 6 || i == 10)});
      chk($sformatf("wr_bank_seq_%0d", i), {31'b0, wr_bank},
          {31'b0, ((i <= 6) || (i == 11))});
      next();
    end
    idle();

    // Bank 0 is readable again: the writes from the last frame, plus the
    // untouched old word.
    read(1, 16'hBEEF); next();
    read(3, 16'h7777); next();
    read(2, 16'h00AC); next();
    idle();
    repeat (4) next();

    // Reset with reads in flight: they must never surface.
    rd_en = 1; rd_address = 0;
    next();
    rd_address = 1; reset = 1;
    next();
    rd_en = 0;
    @(negedge clk);
    chk("rst2_wr_bank", {31'b0, wr_bank}, 0);
    chk("rst2_frame_ready", {31'b0, frame_ready}, 0);
    chk("rst2_rd_data", {16'b0, rd_data}, 0);
    chk("rst2_swap", {31'b0, swap}, 0);
    next();
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rd_valid_after_rst", {31'b0, rd_valid}, 0);
      next();
    end

    // After reset, a lone wr_done swaps.
    wr_done = 1;
    next();
    wr_done = 0;
    @(negedge clk);
    chk("swap_after_reset_wr_done", {31'b0, swap}, 1);
    next();
    @(negedge clk);
    chk("wr_bank_after_reset_swap", {31'b0, wr_bank}, 1);
    chk("frame_ready_after_reset_swap", {31'b0, frame_ready}, 1);
    read(3, 16'h7777);
    next();
    idle();

    t = 0;
    while (sb.size() != 0 && t < 20) begin
      next();
      t++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d reads outstanding, expected 0", sb.size());
    end
    repeat (2) next();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
